// File: rtl/serial_ripple_subtractor_if.sv
// serial_ripple_subtractor_if: operand/result valid-ready bundle for the serial subtractor
interface serial_ripple_subtractor_if #(parameter int N = 4);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic bin;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] diff;
  logic bout;
  logic ovf;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input in_ready, out_valid, diff, bout, ovf
  );
  modport slave (
    input in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - bin, one full-subtractor stage per clock, valid/ready on both sides
module serial_ripple_subtractor #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  serial_ripple_subtractor_if.slave s
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_a, r_b, r_res;
  logic [CW-1:0] r_cnt;
  logic r_br, r_ovf, w_d, w_br, w_last, w_acc;
  always_comb begin
    w_d = r_a[0] ^ r_b[0] ^ r_br;
    w_br = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_last = r_cnt == CW'(N - 1);
    w_acc = (r_state == IDLE) && s.in_valid;
    w_next = w_acc ? SHIFT
           : (r_state == SHIFT && w_last) ? DONE
           : (r_state == DONE && s.out_ready) ? IDLE
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_br <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a <= s.a;
        r_b <= s.b;
        r_br <= s.bin;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_res <= (r_res >> 1) | (N'(w_d) << (N - 1));
        r_br <= w_br;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= w_last & (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
      end
    end
  end
  assign s.in_ready = r_state == IDLE;
  assign s.out_valid = r_state == DONE;
  assign s.diff = r_res;
  assign s.bout = r_br;
  assign s.ovf = r_ovf;
endmodule
